// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM encoding and baud-divider helper for the
//               oversampling UART receiver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

  localparam int c_par_none = 0;
  localparam int c_par_even = 1;
  localparam int c_par_odd  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Rounded clocks per 16x oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud);
    longint num;
    longint den;
    den = longint'(baud) * 16;
    num = longint'(clk_hz) + longint'(baud) * 8;
    return int'(num / den);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
//==============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock show-ahead FIFO; head word is presented whenever
//               the FIFO is non-empty and reads as zero otherwise.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      wr_q;
  logic [c_aw:0]      rd_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               w_wr_en;
  logic               w_rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[c_aw] != rd_q[c_aw]) &&
                   (wr_q[c_aw-1:0] == rd_q[c_aw-1:0]);

  // A pop frees the slot a simultaneous push needs when full.
  assign w_rd_en = pop_i && !empty_o;
  assign w_wr_en = push_i && (!full_o || w_rd_en);

  assign dout_o = empty_o ? '0 : mem_q[rd_q[c_aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_wr_en) wr_q <= wr_q + (c_aw+1)'(1);
      if (w_rd_en) rd_q <= rd_q + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) mem_q[wr_q[c_aw-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ovs.sv
//==============================================================================
// Module      : uart_rx_ovs
// Description : 16x oversampling UART receiver with 3-sample majority voting,
//               optional parity, 1/2 stop bits and a show-ahead receive FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_ovs #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 start,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  import uart_pkg::*;

  localparam int c_div     = calc_div(CLK_HZ, BAUD);
  localparam int c_div_w   = (c_div < 2) ? 1 : $clog2(c_div);
  localparam int c_word_w  = DATA_BITS + 2;
  localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(c_div - 1);
  localparam logic [2:0]         c_last_dat = 3'(DATA_BITS - 1);
  localparam logic [2:0]         c_last_stp = 3'(STOP_BITS - 1);

  generate
    if (c_div < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < c_par_none || PARITY > c_par_odd ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("uart_rx_ovs: illegal parameter set");
    end
  endgenerate

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  prev_q;
  rx_state_e             state_q;
  rx_state_e             state_d;
  logic [c_div_w-1:0]    div_q;
  logic [3:0]            tick_idx_q;
  logic [2:0]            bit_cnt_q;
  logic [1:0]            smp_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_err_q;
  logic                  frm_err_q;

  logic                  w_rx;
  logic                  w_fall;
  logic                  w_tick;
  logic                  w_dec;
  logic                  w_bit;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_word_w-1:0]   w_word;
  logic [c_word_w-1:0]   w_head;

  always_ff @(posedge clk_50m or negedge start) begin
    if (!start) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_rx   = sync2_q;
  assign w_fall = prev_q & ~w_rx;
  assign w_tick = (div_q == c_div_max);
  assign w_dec  = w_tick && (tick_idx_q == 4'd9) && (state_q != ST_IDLE);
  // smp_q[1] holds tick 7, smp_q[0] tick 8; tick 9 is the live sample.
  assign w_bit  = (smp_q[1] & smp_q[0]) | (smp_q[1] & w_rx) | (smp_q[0] & w_rx);

  always_ff @(posedge clk_50m or negedge start) begin
    if (!start) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_fall) state_d = ST_START;
      end
      ST_START: begin
        if (w_dec) state_d = w_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_dec && bit_cnt_q == c_last_dat)
          state_d = (PARITY != c_par_none) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_dec) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (w_dec && bit_cnt_q == c_last_stp) begin
          state_d = ST_IDLE;
          w_push  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters are held at zero while idle so the start edge begins bit timing.
  always_ff @(posedge clk_50m or negedge start) begin
    if (!start) begin
      div_q      <= '0;
      tick_idx_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      div_q      <= '0;
      tick_idx_q <= '0;
      bit_cnt_q  <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      div_q <= w_tick ? '0 : div_q + c_div_w'(1);
      if (w_tick) begin
        tick_idx_q <= tick_idx_q + 4'd1;
        if (tick_idx_q == 4'd7) smp_q[1] <= w_rx;
        if (tick_idx_q == 4'd8) smp_q[0] <= w_rx;
      end
      if (w_dec) begin
        case (state_q)
          ST_DATA:   shift_q   <= {w_bit, shift_q[DATA_BITS-1:1]};
          ST_PARITY: par_err_q <= (((^shift_q) ^ w_bit) != (PARITY == c_par_odd));
          ST_STOP:   if (!w_bit) frm_err_q <= 1'b1;
          default:   ;
        endcase
        bit_cnt_q <= (state_d != state_q) ? 3'd0 : bit_cnt_q + 3'd1;
      end
    end
  end

  assign w_word = {par_err_q, frm_err_q | ~w_bit, shift_q};
  assign w_pop  = ~w_empty & rx_data_ready;

  uart_sync_fifo #(
    .WIDTH (c_word_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_50m),
    .rst_ni  (start),
    .push_i  (w_push),
    .din_i   (w_word),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rx_data       = w_head[DATA_BITS-1:0];
  assign rx_frame_err  = w_head[DATA_BITS];
  assign rx_parity_err = w_head[DATA_BITS+1];
  assign rx_data_valid = ~w_empty;
  assign rx_overrun    = w_push & w_full & ~w_pop;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, data width; legal range 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked: 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive buffer depth in words; power of 2, at least 2.
REQ-007 clk_50m  in  1  the block's single clock; all logic on the rising edge.
REQ-008 start  in  1  reset, asynchronous, active-low.
REQ-009 rx_pin  in  1  asynchronous serial line; idles high.
REQ-010 rx_data  out  DATA_BITS  head-of-FIFO data word.
REQ-011 rx_data_valid  out  1  FIFO holds at least one word.
REQ-012 rx_data_ready  in  1  consumer accepts the head word.
REQ-013 rx_frame_err  out  1  head word had a stop-bit error; qualified by rx_data_valid.
REQ-014 rx_parity_err  out  1  head word had a parity mismatch; qualified by rx_data_valid.
REQ-015 rx_overrun  out  1  one-cycle pulse when a completed word is dropped.
REQ-016 rx_busy  out  1  high while the FSM is outside IDLE.

Function
REQ-017 rx_pin SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-018 Oversample tick every DIV = round(CLK_HZ/(BAUD*16)) cycles; DIV < 2 or out-of-range parameter SHALL fail elaboration.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE->START on a synchronized 1->0 edge; tick and sample counters restart at 0 on that edge.
REQ-021 Each bit value SHALL be the majority of the synchronized samples at ticks 7, 8 and 9 of its 16-tick period, decided at tick 9.
REQ-022 START: majority 1 -> false start, return to IDLE, nothing pushed; majority 0 -> DATA.
REQ-023 DATA: DATA_BITS bits, LSB first; then PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: parity_err = (XOR of data bits ^ received bit) != (PARITY==2).
REQ-025 STOP: each of STOP_BITS bits sampled; any 0 sets frame_err.
REQ-026 After the last stop bit's tick-9 decision, the word {parity_err, frame_err, data} SHALL be pushed in that cycle; FSM -> IDLE that cycle, so a new start edge is accepted from mid-stop.
REQ-027 Break (line held low): frame error pushed once; no new frame until the line returns high and falls again.
REQ-028 FIFO is show-ahead: rx_data_valid rises the cycle after the push; rx_data and flags are stable while valid && !ready.
REQ-029 Pop on rx_data_valid && rx_data_ready.
REQ-030 Push into a full FIFO with no pop in the same cycle: word dropped, rx_overrun high for exactly that cycle, FIFO contents unchanged.
REQ-031 Push and pop in the same cycle when full: both succeed, no overrun.
REQ-032 Push and pop in the same cycle when empty: push only (valid low in that cycle).
REQ-033 Read/write pointers wrap modulo FIFO_DEPTH with an extra bit for full/empty.

Reset
REQ-034 Assertion of start (low) SHALL immediately force state IDLE, clear counters, empty the FIFO, and set synchronizer flops to 1.
REQ-035 During reset all outputs SHALL be 0: rx_data, rx_data_valid, rx_frame_err, rx_parity_err, rx_overrun and rx_busy.
REQ-036 Reset mid-frame discards the partial word; after release the receiver waits for a fresh falling edge.

Structure
REQ-037 Package uart_pkg holds the parity-mode constants, FSM state encoding and the DIV computation function.
REQ-038 The buffer is sub-module uart_sync_fifo (parametrised width and depth, show-ahead, full/empty outputs).

Verification (defaults: DIV=27, bit=432 cycles)
REQ-039 Send 0xA3, 8N1, ready=1 -> one word 0xA3 with both flags 0; valid rises 1 cycle after the stop-bit mid-sample.
REQ-040 PARITY=2, send 0x55 with parity bit 0 -> 0x55 with parity_err=1; with parity bit 1 -> parity_err=0.
REQ-041 Stop bit driven 0 on 0x3C -> 0x3C with frame_err=1; a following 0x81 frame is received clean.
REQ-042 Low glitch of 100 ns on an idle line -> no word, rx_busy back to 0 within one bit time.
REQ-043 ready=0, send 5 frames at depth 4 -> 4 words held in order, rx_overrun pulses once for the 5th.
REQ-044 Assert start mid-data-bit 3 -> outputs 0 at once; a frame sent 2 bit times after release is received correctly.
